// File: rtl/average_sequencer.sv
`default_nettype none
// average_sequencer: accumulates N samples over valid/ready, divides the sum by N
// with a bit-serial restoring divider, and returns avg, remainder and pass flag.
module average_sequencer #(
  parameter  int W         = 4,
  parameter  int N         = 3,
  parameter  int THRESHOLD = 6,
  localparam int SW        = W + $clog2(N),
  localparam int RW        = $clog2(N),
  localparam int CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  avg,
  output logic [RW-1:0] rem,
  output logic          pass,
  output logic          busy,
  output logic [CW-1:0] sample_cnt
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_DIVIDE  = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // One extra bit so the shifted partial remainder (< 2N) can be compared to N.
  localparam int          PW    = RW + 1;
  localparam int          IW    = $clog2(SW + 1);
  localparam logic [PW-1:0] C_N = PW'(N);
  localparam int unsigned C_THR = THRESHOLD;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] div_q, div_d;
  logic [RW-1:0] prem_q, prem_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [W-1:0]  avg_q, avg_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          pass_q, pass_d;

  logic [PW-1:0] trial;
  logic          qbit;
  logic [RW-1:0] step_rem;
  logic [SW-1:0] step_quot;
  logic [SW-1:0] sum_add;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      sum_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      prem_q  <= '0;
      iter_q  <= '0;
      avg_q   <= '0;
      rem_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      prem_q  <= prem_d;
      iter_q  <= iter_d;
      avg_q   <= avg_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    // The dividend register doubles as the quotient register: quotient bits
    // shift in at the LSB as dividend bits leave at the MSB.
    trial     = {prem_q, div_q[SW-1]};
    qbit      = (trial >= C_N);
    step_rem  = qbit ? RW'(trial - C_N) : trial[RW-1:0];
    step_quot = {div_q[SW-2:0], qbit};
    sum_add   = sum_q + SW'(in_data);

    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    prem_d  = prem_q;
    iter_d  = iter_q;
    avg_d   = avg_q;
    rem_d   = rem_q;
    pass_d  = pass_q;

    case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          sum_d = sum_add;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_DIVIDE;
            div_d   = sum_add;
            prem_d  = '0;
            iter_d  = IW'(SW);
          end
        end
      end
      S_DIVIDE: begin
        div_d  = step_quot;
        prem_d = step_rem;
        iter_d = iter_q - IW'(1);
        if (iter_q == IW'(1)) begin
          state_d = S_DONE;
          avg_d   = step_quot[W-1:0];
          rem_d   = step_rem;
          pass_d  = (32'(step_quot[W-1:0]) >= C_THR);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_COLLECT;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_COLLECT;
        sum_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (clear) begin
      state_d = S_COLLECT;
      sum_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    in_ready   = (state_q == S_COLLECT);
    out_valid  = (state_q == S_DONE);
    busy       = (state_q == S_DIVIDE) || (state_q == S_DONE);
    avg        = avg_q;
    rem        = rem_q;
    pass       = pass_q;
    sample_cnt = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_average_sequencer.sv
`default_nettype none
// Directed bench for average_sequencer: vector table plus corner-case sequences.
module tb_average_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] avg;
  logic [1:0] rem;
  logic       pass;
  logic       busy;
  logic [1:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  average_sequencer #(.W(4), .N(3), .THRESHOLD(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .avg        (avg),
    .rem        (rem),
    .pass       (pass),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s0, s1, s2;
    int         gap;
    logic [3:0] avg;
    logic [1:0] rem;
    logic       pass;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [3:0] d, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_result(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, 6);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    send(v.s0, v.gap);
    check({name, "_cnt1"}, int'(sample_cnt), 1);
    send(v.s1, v.gap);
    check({name, "_cnt2"}, int'(sample_cnt), 2);
    send(v.s2, 0);
    check({name, "_busy"}, int'(busy), 1);
    check({name, "_inrdy_div"}, int'(in_ready), 0);
    wait_result(name);
    check({name, "_avg"}, int'(avg), int'(v.avg));
    check({name, "_rem"}, int'(rem), int'(v.rem));
    check({name, "_pass"}, int'(pass), int'(v.pass));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_ov_after"}, int'(out_valid), 0);
    check({name, "_inrdy_after"}, int'(in_ready), 1);
    check({name, "_avg_held"}, int'(avg), int'(v.avg));
  endtask

  initial begin
    bit   bad;
    vec_t v;

    vecs[0] = '{4'd7,  4'd8,  4'd6,  0, 4'd7,  2'd0, 1'b1};
    vecs[1] = '{4'd4,  4'd5,  4'd5,  2, 4'd4,  2'd2, 1'b0};
    vecs[2] = '{4'd5,  4'd7,  4'd3,  0, 4'd5,  2'd0, 1'b0};
    vecs[3] = '{4'd15, 4'd15, 4'd15, 0, 4'd15, 2'd0, 1'b1};
    vecs[4] = '{4'd0,  4'd0,  4'd0,  1, 4'd0,  2'd0, 1'b0};
    vecs[5] = '{4'd5,  4'd6,  4'd6,  0, 4'd5,  2'd2, 1'b0};
    vecs[6] = '{4'd6,  4'd6,  4'd6,  0, 4'd6,  2'd0, 1'b1};
    vecs[7] = '{4'd9,  4'd9,  4'd8,  1, 4'd8,  2'd2, 1'b1};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(sample_cnt), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_pass", int'(pass), 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, inputs ignored, a single handoff.
    send(4'd6, 0); send(4'd6, 0); send(4'd6, 0);
    wait_result("bp");
    in_valid = 1'b1; in_data = 4'd15;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ov", int'(out_valid), 1);
      check("bp_avg", int'(avg), 6);
      check("bp_pass", int'(pass), 1);
      check("bp_inrdy", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_cnt_after", int'(sample_cnt), 0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("bp_single_handoff", int'(bad), 0);
    v = '{4'd2, 4'd2, 4'd2, 0, 4'd2, 2'd0, 1'b0};
    run_vec("bp_next", v);

    // Clear in COLLECT drops the partial sum and the same-cycle sample.
    send(4'd10, 0); send(4'd10, 0);
    check("clr_cnt_before", int'(sample_cnt), 2);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd10;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("clr_cnt", int'(sample_cnt), 0);
    check("clr_inrdy", int'(in_ready), 1);
    v = '{4'd1, 4'd1, 4'd1, 0, 4'd1, 2'd0, 1'b0};
    run_vec("clr_next", v);

    // Clear mid-divide: no result, avg keeps its last value.
    send(4'd3, 0); send(4'd3, 0); send(4'd3, 0);
    repeat (2) @(negedge clk);
    check("clrdiv_busy_before", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clrdiv_busy", int'(busy), 0);
    check("clrdiv_inrdy", int'(in_ready), 1);
    bad = 1'b0;
    repeat (10) begin
      if (out_valid) bad = 1'b1;
      @(negedge clk);
    end
    check("clrdiv_no_ov", int'(bad), 0);
    check("clrdiv_avg_kept", int'(avg), 1);

    // Clear beats out_ready in DONE; fields are kept.
    send(4'd9, 0); send(4'd9, 0); send(4'd9, 0);
    wait_result("clrdone");
    out_ready = 1'b1; clear = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clear = 1'b0;
    check("clrdone_ov", int'(out_valid), 0);
    check("clrdone_avg_kept", int'(avg), 9);
    check("clrdone_pass_kept", int'(pass), 1);

    // Reset while a result is pending.
    send(4'd12, 0); send(4'd12, 0); send(4'd12, 0);
    wait_result("rstdone");
    check("rstdone_ov_before", int'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstdone_ov", int'(out_valid), 0);
    check("rstdone_avg", int'(avg), 0);
    check("rstdone_pass", int'(pass), 0);
    check("rstdone_inrdy", int'(in_ready), 1);
    check("rstdone_cnt", int'(sample_cnt), 0);
    v = '{4'd10, 4'd10, 4'd10, 0, 4'd10, 2'd0, 1'b1};
    run_vec("rst_next", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/average_sequencer.md
Name: average_sequencer

Overview:
Sequential grade-averaging controller for the three-input average/threshold datapath. It accepts N unsigned samples one at a time over a valid/ready stream and accumulates them. It then divides the sum by N with a bit-serial restoring divider. It returns the truncated average, the remainder and a pass flag (average >= THRESHOLD) over a valid/ready result handshake. This lets one narrow datapath serve a serial grade source instead of three parallel input buses.

Parameters:
W, 4, sample width in bits (unsigned)
N, 3, samples per average; N >= 2
THRESHOLD, 6, pass limit compared against the truncated average
SW, W+$clog2(N), sum width, derived; 6 for defaults; localparam, not overridable
RW, $clog2(N), remainder width, derived; 2 for defaults

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
clear  in  1  synchronous abort: discards partial sum and any result in progress
in_valid  in  1  sample present on in_data
in_ready  out  1  block can accept a sample
in_data  in  W  unsigned sample
out_valid  out  1  result fields valid
out_ready  in  1  consumer takes result
avg  out  W  floor(sum/N)
rem  out  RW  sum mod N
pass  out  1  1 when avg >= THRESHOLD
busy  out  1  high in DIVIDE or DONE
sample_cnt  out  $clog2(N+1)  samples accepted in current group

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=COLLECT, sum=0, sample_cnt=0.
  - out_valid=0, avg=0, rem=0, pass=0, busy=0, in_ready=1 after the edge.
  - Reset overrides clear and all handshakes, in any state.
- States: COLLECT, DIVIDE, DONE.
- COLLECT:
  - in_ready=1 (registered state decode, no combinational path from in_valid).
  - Accept when in_valid&&in_ready: sum += in_data (SW bits, cannot overflow), sample_cnt++.
  - Idle cycles with in_valid=0 are allowed between samples.
  - On the edge accepting sample N: go to DIVIDE, load dividend=sum+in_data, clear the remainder register, set the iteration counter to SW.
- DIVIDE:
  - in_ready=0, busy=1.
  - One restoring step per cycle, MSB first: shift the partial remainder left and bring in the next dividend bit. If the result is >= N, subtract N and set the quotient bit.
  - Exactly SW cycles. out_valid rises after the SW-th edge following the accepting edge (6 cycles for defaults).
  - The quotient is always < 2^W; truncate it to W bits for avg.
- DONE:
  - out_valid=1; avg, rem and pass held stable while out_valid=1 and out_ready=0.
  - pass = (avg >= THRESHOLD), unsigned compare on the truncated average. A sum of 17 with N=3 gives avg 5, so pass=0.
  - On out_valid&&out_ready: go to COLLECT, out_valid=0, sum=0, sample_cnt=0. in_ready=1 from the next cycle (no same-cycle bypass).
  - avg, rem and pass keep their last values after handoff until the next result.
- in_valid while in_ready=0 is ignored; the source must hold data (standard valid/ready).
- clear=1 at an edge, in any state: state=COLLECT, sum=0, sample_cnt=0, out_valid=0, busy=0.
  - A sample offered in the same cycle is dropped, and any pending result is discarded.
  - avg, rem and pass are not cleared.
- clear and out_ready in the same cycle: clear wins, and the result counts as not delivered.

Test Plan:
1. Stream 7,8,6 back-to-back, out_ready=1 -> out_valid rises 6 cycles after the 3rd accept; avg=7, rem=0, pass=1; in_ready high again the cycle after handoff.
2. Stream 4,5,5 with 2-cycle in_valid gaps -> sample_cnt steps 1,2, then busy; avg=4, rem=2, pass=0. Then 5,7,3 -> avg=5, rem=0, pass=0.
3. Stream 15,15,15 -> sum=45, avg=15, rem=0, pass=1 (full-scale). Stream 0,0,0 -> avg=0, rem=0, pass=0.
4. Backpressure: after 6,6,6 hold out_ready=0 for 10 cycles -> out_valid stays 1, avg=6 and pass=1 stable, in_ready=0 and in_valid ignored. Release -> one handoff only.
5. Accept 10,10, then pulse clear -> sample_cnt=0. Then 1,1,1 -> avg=1, pass=0, proving the stale partial sum is gone. Also pulse clear mid-DIVIDE -> no out_valid, block back in COLLECT.
6. Drive rst_n=0 for one edge in DONE with out_valid=1 -> out_valid=0, avg=0, in_ready=1. Then 10,10,10 -> avg=10, pass=1.
